// File: rtl/shiftregister_universal.sv
// -----------------------------------------------------------------------------
// shiftregister_universal
//   Parametrised universal shift register with the following operations:
//   hold, shift right and left with serial inputs, rotate right and left, and
//   synchronous parallel preset. A step counter tracks consecutive rotate steps
//   in one direction. rotation_done pulses for one cycle after each full
//   revolution.
//   With WIDTH=5 and mode=ROR this block behaves as the old fixed 5-bit
//   circular right shifter.
//
//   Optional feature macro: SHIFTREG_UNIVERSAL_JOHNSON_EN
//     When defined, mode 101 is a Johnson (twisted-ring) shift. The twisted
//     ring is counted as its own direction, with a wrap limit of 2*WIDTH.
//     When undefined, mode 101 holds like the reserved codes.
// -----------------------------------------------------------------------------
module shiftregister_universal #(
  parameter  int WIDTH = 5,
  localparam int CNT_W = $clog2(2 * WIDTH + 1)
) (
  input  logic             clockpulse,
  input  logic             clear,
  input  logic [2:0]       mode,
  input  logic             serial_in_right,
  input  logic             serial_in_left,
  input  logic             preset_enable,
  input  logic [WIDTH-1:0] preset,
  output logic [WIDTH-1:0] signal_q,
  output logic [WIDTH-1:0] signal_q_,
  output logic             serial_out_right,
  output logic             serial_out_left,
  output logic [CNT_W-1:0] step_count,
  output logic             rotation_done
);

  localparam logic [2:0] MODE_HOLD    = 3'b000;
  localparam logic [2:0] MODE_SHR     = 3'b001;
  localparam logic [2:0] MODE_SHL     = 3'b010;
  localparam logic [2:0] MODE_ROR     = 3'b011;
  localparam logic [2:0] MODE_ROL     = 3'b100;
  localparam logic [2:0] MODE_JOHNSON = 3'b101;

  localparam logic [CNT_W-1:0] LIM_ROT  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LIM_JOHN = CNT_W'(2 * WIDTH);

  // Direction of the rotate sequence that is currently being counted.
  typedef enum logic [1:0] {
    DIR_NONE  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_TWIST = 2'b11
  } dir_e;

  logic [WIDTH-1:0] q_q,    q_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic             done_q, done_d;
  dir_e             dir_q,  dir_d;

  logic             rot_s;
  dir_e             rot_dir_s;
  logic [CNT_W-1:0] lim_s;
  logic [CNT_W-1:0] step_inc_s;

  // Next-state logic: data path operation, rotate step counting, and wrap detection.
  always_comb begin
    q_d        = q_q;
    step_d     = step_q;
    dir_d      = dir_q;
    done_d     = 1'b0;
    rot_s      = 1'b0;
    rot_dir_s  = DIR_NONE;
    lim_s      = LIM_ROT;
    step_inc_s = step_q;

    if (preset_enable) begin
      // Preset wins over any mode and restarts the revolution tracking.
      q_d    = preset;
      step_d = {CNT_W{1'b0}};
      dir_d  = DIR_NONE;
    end else begin
      case (mode)
        MODE_HOLD: begin
          q_d = q_q;
        end
        MODE_SHR: begin
          q_d    = {serial_in_right, q_q[WIDTH-1:1]};
          step_d = {CNT_W{1'b0}};
          dir_d  = DIR_NONE;
        end
        MODE_SHL: begin
          q_d    = {q_q[WIDTH-2:0], serial_in_left};
          step_d = {CNT_W{1'b0}};
          dir_d  = DIR_NONE;
        end
        MODE_ROR: begin
          q_d       = {q_q[0], q_q[WIDTH-1:1]};
          rot_s     = 1'b1;
          rot_dir_s = DIR_RIGHT;
        end
        MODE_ROL: begin
          q_d       = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          rot_s     = 1'b1;
          rot_dir_s = DIR_LEFT;
        end
`ifdef SHIFTREG_UNIVERSAL_JOHNSON_EN
        MODE_JOHNSON: begin
          q_d       = {~q_q[0], q_q[WIDTH-1:1]};
          rot_s     = 1'b1;
          rot_dir_s = DIR_TWIST;
          lim_s     = LIM_JOHN;
        end
`else
        MODE_JOHNSON: begin
          q_d = q_q;
        end
`endif
        default: begin
          // Reserved codes hold and leave the counter untouched.
          q_d = q_q;
        end
      endcase

      if (rot_s) begin
        // A change of direction starts a new revolution at step 1.
        step_inc_s = (dir_q == rot_dir_s) ? (step_q + {{(CNT_W-1){1'b0}}, 1'b1})
                                          : {{(CNT_W-1){1'b0}}, 1'b1};
        dir_d = rot_dir_s;
        if (step_inc_s == lim_s) begin
          step_d = {CNT_W{1'b0}};
          done_d = 1'b1;
        end else begin
          step_d = step_inc_s;
        end
      end else begin
        step_inc_s = step_q;
      end
    end
  end

  // State registers. clear resets them asynchronously, so the outputs clear immediately.
  always_ff @(posedge clockpulse or negedge clear) begin
    if (!clear) begin
      q_q    <= {WIDTH{1'b0}};
      step_q <= {CNT_W{1'b0}};
      done_q <= 1'b0;
      dir_q  <= DIR_NONE;
    end else begin
      q_q    <= q_d;
      step_q <= step_d;
      done_q <= done_d;
      dir_q  <= dir_d;
    end
  end

  assign signal_q         = q_q;
  assign signal_q_        = ~q_q;
  assign serial_out_right = q_q[0];
  assign serial_out_left  = q_q[WIDTH-1];
  assign step_count       = step_q;
  assign rotation_done    = done_q;

endmodule

// File: tb/tb_shiftregister_universal.sv
// -----------------------------------------------------------------------------
// tb_shiftregister_universal
//   Directed, table-driven bench for shiftregister_universal with WIDTH=5.
//   Each table row is applied for one rising edge and then compared. Hand-written
//   sequences cover the asynchronous clear and the Johnson / mode-101 behaviour.
//   These sequences follow SHIFTREG_UNIVERSAL_JOHNSON_EN.
// -----------------------------------------------------------------------------
module tb_shiftregister_universal;

  localparam int W  = 5;
  localparam int CW = 4;

  logic          clk;
  logic          clear;
  logic [2:0]    mode;
  logic          sir;
  logic          sil;
  logic          pe;
  logic [W-1:0]  pre;
  logic [W-1:0]  q;
  logic [W-1:0]  qn;
  logic          sor;
  logic          sol;
  logic [CW-1:0] step;
  logic          done;

  int n_tests;
  int n_fail;

  shiftregister_universal #(.WIDTH(W)) dut (
    .clockpulse       (clk),
    .clear            (clear),
    .mode             (mode),
    .serial_in_right  (sir),
    .serial_in_left   (sil),
    .preset_enable    (pe),
    .preset           (pre),
    .signal_q         (q),
    .signal_q_        (qn),
    .serial_out_right (sor),
    .serial_out_left  (sol),
    .step_count       (step),
    .rotation_done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          pe;
    logic [W-1:0]  pre;
    logic [2:0]    mode;
    logic          sir;
    logic          sil;
    logic [W-1:0]  q;
    logic [CW-1:0] step;
    logic          done;
  } vec_t;

  localparam int NV = 33;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] eq,
                         input logic [CW-1:0] es, input logic ed);
    logic [W-1:0] eqn;
    eqn = ~eq;
    chk({tag, ".q"},    32'(q),    32'(eq));
    chk({tag, ".q_"},   32'(qn),   32'(eqn));
    chk({tag, ".sor"},  32'(sor),  32'(eq[0]));
    chk({tag, ".sol"},  32'(sol),  32'(eq[W-1]));
    chk({tag, ".step"}, 32'(step), 32'(es));
    chk({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  task automatic setv(input int i, input logic p, input logic [W-1:0] pv, input logic [2:0] m,
                      input logic r, input logic l, input logic [W-1:0] eq,
                      input logic [CW-1:0] es, input logic ed);
    tbl[i].pe = p;  tbl[i].pre = pv; tbl[i].mode = m; tbl[i].sir = r; tbl[i].sil = l;
    tbl[i].q  = eq; tbl[i].step = es; tbl[i].done = ed;
  endtask

  // Drives the inputs, waits for one rising edge, then samples 1 time unit later.
  task automatic step_edge(input logic p, input logic [W-1:0] pv, input logic [2:0] m,
                           input logic r, input logic l);
    pe = p; pre = pv; mode = m; sir = r; sil = l;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //        pe    preset    mode    sir   sil   exp q     step   done
    setv( 0, 1'b1, 5'b10000, 3'b000, 1'b0, 1'b0, 5'b10000, 4'd0, 1'b0);
    setv( 1, 1'b0, 5'b00000, 3'b011, 1'b0, 1'b0, 5'b01000, 4'd1, 1'b0);
    setv( 2, 1'b0, 5'b00000, 3'b011, 1'b0, 1'b0, 5'b00100, 4'd2, 1'b0);
    setv( 3, 1'b0, 5'b00000, 3'b011, 1'b0, 1'b0, 5'b00010, 4'd3, 1'b0);
    setv( 4, 1'b0, 5'b00000, 3'b011, 1'b0, 1'b0, 5'b00001, 4'd4, 1'b0);
    setv( 5, 1'b0, 5'b00000, 3'b011, 1'b0, 1'b0, 5'b10000, 4'd0, 1'b1);
    setv( 6, 1'b0, 5'b00000, 3'b000, 1'b0, 1'b0, 5'b10000, 4'd0, 1'b0);
    setv( 7, 1'b1, 5'b00000, 3'b000, 1'b0, 1'b0, 5'b00000, 4'd0, 1'b0);
    setv( 8, 1'b0, 5'b00000, 3'b001, 1'b1, 1'b0, 5'b10000, 4'd0, 1'b0);
    setv( 9, 1'b0, 5'b00000, 3'b001, 1'b0, 1'b0, 5'b01000, 4'd0, 1'b0);
    setv(10, 1'b0, 5'b00000, 3'b001, 1'b1, 1'b0, 5'b10100, 4'd0, 1'b0);
    setv(11, 1'b0, 5'b00000, 3'b010, 1'b0, 1'b1, 5'b01001, 4'd0, 1'b0);
    setv(12, 1'b0, 5'b00000, 3'b011, 1'b0, 1'b0, 5'b10100, 4'd1, 1'b0);
    setv(13, 1'b0, 5'b00000, 3'b011, 1'b0, 1'b0, 5'b01010, 4'd2, 1'b0);
    setv(14, 1'b0, 5'b00000, 3'b000, 1'b0, 1'b0, 5'b01010, 4'd2, 1'b0);
    setv(15, 1'b0, 5'b00000, 3'b000, 1'b0, 1'b0, 5'b01010, 4'd2, 1'b0);
    setv(16, 1'b0, 5'b00000, 3'b000, 1'b0, 1'b0, 5'b01010, 4'd2, 1'b0);
    setv(17, 1'b0, 5'b00000, 3'b011, 1'b0, 1'b0, 5'b00101, 4'd3, 1'b0);
    setv(18, 1'b0, 5'b00000, 3'b011, 1'b0, 1'b0, 5'b10010, 4'd4, 1'b0);
    setv(19, 1'b0, 5'b00000, 3'b011, 1'b0, 1'b0, 5'b01001, 4'd0, 1'b1);
    setv(20, 1'b0, 5'b00000, 3'b011, 1'b0, 1'b0, 5'b10100, 4'd1, 1'b0);
    setv(21, 1'b0, 5'b00000, 3'b011, 1'b0, 1'b0, 5'b01010, 4'd2, 1'b0);
    setv(22, 1'b0, 5'b00000, 3'b100, 1'b0, 1'b0, 5'b10100, 4'd1, 1'b0);
    setv(23, 1'b0, 5'b00000, 3'b011, 1'b0, 1'b0, 5'b01010, 4'd1, 1'b0);
    setv(24, 1'b0, 5'b00000, 3'b011, 1'b0, 1'b0, 5'b00101, 4'd2, 1'b0);
    setv(25, 1'b0, 5'b00000, 3'b011, 1'b0, 1'b0, 5'b10010, 4'd3, 1'b0);
    setv(26, 1'b1, 5'b11011, 3'b011, 1'b0, 1'b0, 5'b11011, 4'd0, 1'b0);
    setv(27, 1'b0, 5'b00000, 3'b011, 1'b0, 1'b0, 5'b11101, 4'd1, 1'b0);
    setv(28, 1'b0, 5'b00000, 3'b110, 1'b1, 1'b1, 5'b11101, 4'd1, 1'b0);
    setv(29, 1'b0, 5'b00000, 3'b111, 1'b1, 1'b1, 5'b11101, 4'd1, 1'b0);
    setv(30, 1'b0, 5'b00000, 3'b010, 1'b1, 1'b0, 5'b11010, 4'd0, 1'b0);
    setv(31, 1'b0, 5'b00000, 3'b011, 1'b0, 1'b1, 5'b01101, 4'd1, 1'b0);
    setv(32, 1'b0, 5'b00000, 3'b001, 1'b0, 1'b1, 5'b00110, 4'd0, 1'b0);

    // Reset state, asserted before any clock edge.
    clear = 1'b0; pe = 1'b0; pre = 5'b00000; mode = 3'b000; sir = 1'b0; sil = 1'b0;
    #2;
    chk_all("reset", 5'b00000, 4'd0, 1'b0);
    @(negedge clk);
    clear = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      step_edge(tbl[i].pe, tbl[i].pre, tbl[i].mode, tbl[i].sir, tbl[i].sil);
      chk_all($sformatf("vec%0d", i), tbl[i].q, tbl[i].step, tbl[i].done);
    end

    // Asynchronous clear in the middle of a rotate sequence.
    step_edge(1'b1, 5'b10110, 3'b000, 1'b0, 1'b0);
    chk_all("clr.pre", 5'b10110, 4'd0, 1'b0);
    step_edge(1'b0, 5'b00000, 3'b011, 1'b0, 1'b0);
    step_edge(1'b0, 5'b00000, 3'b011, 1'b0, 1'b0);
    chk_all("clr.run", 5'b10101, 4'd2, 1'b0);
    #2;
    clear = 1'b0;
    #1;
    chk_all("clr.async", 5'b00000, 4'd0, 1'b0);
    @(negedge clk);
    clear = 1'b1;
    step_edge(1'b1, 5'b00001, 3'b000, 1'b0, 1'b0);
    step_edge(1'b0, 5'b00000, 3'b011, 1'b0, 1'b0);
    chk_all("clr.restart", 5'b10000, 4'd1, 1'b0);

    // Mode 101 from q=00000 for ten edges.
    step_edge(1'b1, 5'b00000, 3'b000, 1'b0, 1'b0);
    begin
      logic [W-1:0] jq;
      logic [W-1:0] eq;
      logic [CW-1:0] es;
      logic ed;
      jq = 5'b00000;
      for (int k = 1; k <= 10; k++) begin
`ifdef SHIFTREG_UNIVERSAL_JOHNSON_EN
        jq = {~jq[0], jq[W-1:1]};
        eq = jq;
        es = (k == 10) ? 4'd0 : CW'(k);
        ed = (k == 10) ? 1'b1 : 1'b0;
`else
        eq = 5'b00000;
        es = 4'd0;
        ed = 1'b0;
`endif
        step_edge(1'b0, 5'b00000, 3'b101, 1'b1, 1'b1);
        chk_all($sformatf("m101.%0d", k), eq, es, ed);
      end
      step_edge(1'b0, 5'b00000, 3'b000, 1'b0, 1'b0);
      chk("m101.done_clr", 32'(done), 32'(1'b0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
